// File: rtl/aes_gcm_seq.sv
// aes_gcm_seq: sequential AES-128-GCM encryption controller for multi-block messages.
//
// This module drives one shared iterative AES engine over a req/ack handshake.
// It first derives H = E_K(0) and then E_K(J0). After that it streams AAD and
// data blocks in and ciphertext blocks out. Every block is folded into a
// registered GHASH accumulator through a single combinational gf128_mult.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, iv[95:0], busy        message start (IDLE only), IV, busy flag
//   in_valid/in_ready/in_data/in_aad/in_last
//                                host input stream (full 128-bit blocks)
//   out_valid/out_ready/out_data ciphertext output stream
//   tag_valid, auth_tag, err     tag result and sticky protocol error
//   aes_req/aes_block/aes_ack/aes_result
//                                shared AES engine handshake
//
// Optional build macro AES_GCM_SEQ_DECRYPT_EN:
//   decrypt (latched on start), exp_tag (sampled in TAG), tag_ok.
//   With decrypt=1, GHASH folds the incoming ciphertext and out_data carries plaintext.

module gf128_mult (
  input  logic [127:0] x_i,
  input  logic [127:0] y_i,
  output logic [127:0] z_o
);
  logic [127:0] v;

  // Bit-reflected GF(2^128) product; the block MSB is the x^0 coefficient.
  always_comb begin
    z_o = '0;
    v   = y_i;
    for (int unsigned i = 0; i < 128; i++) begin
      if (x_i[127 - i]) z_o = z_o ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
  end
endmodule

module aes_gcm_seq #(
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [95:0]  iv,
  output logic         busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_aad,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         tag_valid,
  output logic [127:0] auth_tag,
  output logic         err,
`ifdef AES_GCM_SEQ_DECRYPT_EN
  input  logic         decrypt,
  input  logic [127:0] exp_tag,
  output logic         tag_ok,
`endif
  output logic         aes_req,
  output logic [127:0] aes_block,
  input  logic         aes_ack,
  input  logic [127:0] aes_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_HGEN, S_J0GEN, S_IN, S_CTR, S_OUT, S_LEN, S_TAG
  } state_e;

  state_e             state_q;
  logic [95:0]        iv_q;
  logic [127:0]       h_q, ej0_q, s_q, ctr_q, buf_q;
  logic [CNT_W-1:0]   aad_cnt_q, data_cnt_q;
  logic               last_q, data_seen_q;
  logic               busy_q, in_ready_q, out_valid_q, tag_valid_q, err_q, aes_req_q;
  logic [127:0]       out_data_q, auth_tag_q, aes_block_q;
  logic [127:0]       ghash_x, s_d, fold_blk;
  logic [63:0]        len_a, len_c;
  logic               ack_ok;

`ifdef AES_GCM_SEQ_DECRYPT_EN
  logic dec_q, tag_ok_q;
  assign fold_blk = dec_q ? buf_q : out_data_q;
  assign tag_ok   = tag_ok_q;
`else
  assign fold_blk = out_data_q;
`endif

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign tag_valid = tag_valid_q;
  assign auth_tag  = auth_tag_q;
  assign err       = err_q;
  assign aes_req   = aes_req_q;
  assign aes_block = aes_block_q;

  // An ack only counts while a request is outstanding.
  assign ack_ok = aes_req_q & aes_ack;
  assign len_a  = 64'(aad_cnt_q) << 7;
  assign len_c  = 64'(data_cnt_q) << 7;

  // The single multiplier input is selected by state.
  always_comb begin
    ghash_x = s_q;
    case (state_q)
      S_IN:    ghash_x = s_q ^ in_data;
      S_OUT:   ghash_x = s_q ^ fold_blk;
      S_LEN:   ghash_x = s_q ^ {len_a, len_c};
      default: ghash_x = s_q;
    endcase
  end

  gf128_mult u_gf (.x_i(ghash_x), .y_i(h_q), .z_o(s_d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      iv_q        <= '0;
      h_q         <= '0;
      ej0_q       <= '0;
      s_q         <= '0;
      ctr_q       <= '0;
      buf_q       <= '0;
      aad_cnt_q   <= '0;
      data_cnt_q  <= '0;
      last_q      <= 1'b0;
      data_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      tag_valid_q <= 1'b0;
      err_q       <= 1'b0;
      aes_req_q   <= 1'b0;
      out_data_q  <= '0;
      auth_tag_q  <= '0;
      aes_block_q <= '0;
`ifdef AES_GCM_SEQ_DECRYPT_EN
      dec_q       <= 1'b0;
      tag_ok_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          iv_q        <= iv;
          s_q         <= '0;
          aad_cnt_q   <= '0;
          data_cnt_q  <= '0;
          data_seen_q <= 1'b0;
          err_q       <= 1'b0;
          tag_valid_q <= 1'b0;
          busy_q      <= 1'b1;
          aes_req_q   <= 1'b1;
          aes_block_q <= '0;
`ifdef AES_GCM_SEQ_DECRYPT_EN
          dec_q       <= decrypt;
          tag_ok_q    <= 1'b0;
`endif
          state_q     <= S_HGEN;
        end
        S_HGEN: if (ack_ok) begin
          h_q         <= aes_result;
          aes_block_q <= {iv_q, 32'h1};
          state_q     <= S_J0GEN;
        end
        S_J0GEN: if (ack_ok) begin
          ej0_q      <= aes_result;
          ctr_q      <= {iv_q, 32'h2};
          aes_req_q  <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= S_IN;
        end
        S_IN: if (in_valid && in_ready_q) begin
          if (in_aad) begin
            // AAD after ciphertext has started is dropped and flagged.
            if (data_seen_q) begin
              err_q <= 1'b1;
            end else begin
              s_q       <= s_d;
              aad_cnt_q <= aad_cnt_q + CNT_W'(1);
            end
            if (in_last) begin
              in_ready_q <= 1'b0;
              state_q    <= S_LEN;
            end
          end else begin
            buf_q       <= in_data;
            last_q      <= in_last;
            data_seen_q <= 1'b1;
            in_ready_q  <= 1'b0;
            aes_req_q   <= 1'b1;
            aes_block_q <= ctr_q;
            state_q     <= S_CTR;
          end
        end
        S_CTR: if (ack_ok) begin
          out_data_q  <= buf_q ^ aes_result;
          out_valid_q <= 1'b1;
          aes_req_q   <= 1'b0;
          state_q     <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          s_q         <= s_d;
          data_cnt_q  <= data_cnt_q + CNT_W'(1);
          ctr_q[31:0] <= ctr_q[31:0] + 32'd1;
          out_valid_q <= 1'b0;
          if (last_q) begin
            state_q <= S_LEN;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= S_IN;
          end
        end
        S_LEN: begin
          s_q     <= s_d;
          state_q <= S_TAG;
        end
        S_TAG: begin
          auth_tag_q  <= s_q ^ ej0_q;
          tag_valid_q <= 1'b1;
          busy_q      <= 1'b0;
`ifdef AES_GCM_SEQ_DECRYPT_EN
          tag_ok_q    <= ((s_q ^ ej0_q) == exp_tag);
`endif
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_gcm_seq.md
Name: aes_gcm_seq

Overview:
- Sequential AES-128-GCM encryption controller for multi-block messages.
- Drives one shared iterative AES engine over a req/ack handshake. Derives H = E_K(0) and E_K(J0), then streams AAD and plaintext blocks in and ciphertext blocks out.
- Folds each block into a registered GHASH accumulator using an internal gf128_mult instance.
- Sits between the host stream interface and the AES engine. The key is loaded into the engine externally.

Parameters:
- CNT_W, 32, width of the AAD and data block counters (lengths = count*128, zero-extended to 64 bits).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin message; accepted only in IDLE
- iv  in  96  IV, latched on the accepted start
- busy  out  1  high from accepted start until tag_valid rises
- in_valid  in  1  input beat valid
- in_ready  out  1  controller can accept a beat
- in_data  in  128  AAD or plaintext block, left-aligned, full blocks only
- in_aad  in  1  beat is AAD (1) or plaintext (0)
- in_last  in  1  final beat of the message
- out_valid  out  1  ciphertext block valid
- out_ready  in  1  downstream accepts ciphertext
- out_data  out  128  ciphertext block
- tag_valid  out  1  auth_tag valid; held until the next accepted start
- auth_tag  out  128  GCM tag
- err  out  1  protocol error flag (sticky until next start)
- aes_req  out  1  AES request, held until aes_ack
- aes_block  out  128  AES input block, stable while aes_req=1
- aes_ack  in  1  one-cycle pulse; aes_result valid this cycle
- aes_result  in  128  AES output block

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - H, EJ0, S (GHASH accumulator), ctr, counters and the data buffer all cleared.
  - Reset mid-operation aborts immediately; aes_req drops, and any aes_ack arriving later is ignored.
- IDLE:
  - start=1 latches iv; clears S, the counters, err and tag_valid; sets busy=1; goes to HGEN.
  - start while not in IDLE is ignored.
- HGEN: aes_req=1, aes_block=0. On aes_ack, H<=aes_result, go to J0GEN.
- J0GEN:
  - aes_req=1, aes_block={iv,32'h1}. On aes_ack, EJ0<=aes_result.
  - Set ctr={iv,32'h2}, go to IN.
- IN: in_ready=1. On in_valid handshake:
  - AAD beat (in_aad=1):
    - If any data beat has already been accepted: err<=1 and the beat is dropped.
    - Otherwise: S<=(S^in_data)*H, aad_cnt++.
    - Next state is LEN if in_last, else stay in IN.
  - Data beat (in_aad=0): buf<=in_data, last_q<=in_last, go to CTR.
- CTR:
  - aes_req=1, aes_block=ctr; in_ready=0.
  - On aes_ack, out_data<=buf^aes_result, go to OUT.
- OUT:
  - out_valid=1; out_data is stable until out_ready.
  - On out_ready: S<=(S^out_data)*H, data_cnt++, and inc32 on ctr (low 32 bits wrap mod 2^32, no carry into the IV).
  - Next state is LEN if last_q, else IN.
- LEN: one cycle. S<=(S^{aad_cnt*128 as 64b, data_cnt*128 as 64b})*H, go to TAG.
- TAG: auth_tag<=S^EJ0, tag_valid<=1, busy<=0, go to IDLE.
- Latency:
  - H/J0 setup costs 2 AES latencies.
  - Each AAD beat costs 1 cycle.
  - Each data beat costs 1 + AES latency + 1 + out_ready stall.
  - Tag appears 2 cycles after the last GHASH update.
- Boundary conditions:
  - A message needs at least one beat. An AAD-only message (in_last on an AAD beat) gives a zero-length ciphertext; len block = {aad_cnt*128, 64'h0}.
  - aes_ack while aes_req=0 is ignored.
  - Counter overflow beyond 2^CNT_W-1 blocks wraps silently; the caller must stay below it.

Optional Feature:
- Macro: AES_GCM_SEQ_DECRYPT_EN.
- Present: adds ports
  - decrypt (in 1, latched on start)
  - exp_tag (in 128, sampled in TAG)
  - tag_ok (out 1, reset 0, valid with tag_valid)
- Present, decrypt=1: GHASH folds in_data (the ciphertext) instead of out_data; out_data is the plaintext. tag_ok = (auth_tag==exp_tag).
- Absent: encrypt only; ports omitted.

Test Plan:
- Engine model: key=0, AES latency 10.
- NIST TC2: key=0, iv=0, one data beat pt=0 with in_last.
  - Expect aes_block=0, then {0,32'h1}, then {0,32'h2}.
  - Expect H=66e94bd4ef8a2c3b884cfa59ca342b2e, out_data=0388dace60b6a392f328c2b971b2fe78, auth_tag=ab6e47d42cec13bdf53a67b21257bddf.
- 1 AAD + 3 data beats with random out_ready stalls: outputs stable under stall; ctr low words 2, 3, 4; tag matches the golden GCM model; len block = {64'd128, 64'd384}.
- AAD beat after a data beat: err=1, beat dropped, tag still produced over the remaining beats.
- iv low word wrap check: ctr low word 32'hFFFFFFFF then 32'h0, iv bits unchanged; start during busy ignored.
- rst_n=0 during CTR: outputs 0 immediately. A late aes_ack is ignored. A fresh TC2 run then passes.
